bsg_axil_cmd_to_master: RTL

- AXI4-Lite initiator that converts single-beat read/write commands into AXI-Lite master channel traffic.
- Returns one response per command, carrying the response code, read data and a measured round-trip latency.
- Used in cosim and standalone benches to drive AXI-Lite slave ports of DUT shells.
- Exactly one transaction outstanding at any time.

---
 rtl/bsg_axil_cmd_to_master_pkg.sv | 20 ++
 rtl/bsg_axil_cmd_to_master_if.sv | 39 +++
 rtl/bsg_axil_lat_counter.sv | 29 ++
 rtl/bsg_axil_cmd_to_master.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bsg_axil_cmd_to_master_pkg.sv
// Shared definitions for the AXI4-Lite command initiator.
//   state_e      : transaction FSM states
//   RESP_*       : AXI response code constants
package bsg_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/bsg_axil_cmd_to_master_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master : initiator view (drives valids, addresses, data, bready/rready)
//   slave  : target view (drives readies, responses, read data)
interface bsg_axil_cmd_to_master_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic [addr_width_p-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [addr_width_p-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/bsg_axil_lat_counter.sv
// Saturating up-counter with synchronous clear.
//   clear_i : restart from 0 (an increment in the same cycle still applies)
//   inc_i   : add one unless already at all-ones
//   count_o : current count
module bsg_axil_lat_counter #(
    parameter int width_p = 16
) (
    input  logic               aclk_i,
    input  logic               aresetn_i,
    input  logic               clear_i,
    input  logic               inc_i,
    output logic [width_p-1:0] count_o
);
    logic [width_p-1:0] cnt_q, cnt_d, base;

    always_comb begin
        base  = clear_i ? '0 : cnt_q;
        cnt_d = base;
        if (inc_i && (base != '1))
            cnt_d = base + width_p'(1);
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/bsg_axil_cmd_to_master.sv
// AXI4-Lite initiator: turns single-beat read/write commands into AXI-Lite
// master traffic, one transaction in flight, and returns one response per
// command with the response code, read data and round-trip latency.
//   cmd_*   : command in (valid/ready)
//   resp_*  : response out (valid/ready), lat = cycles accept..B/R handshake
//   m_axil  : AXI-Lite master port
module bsg_axil_cmd_to_master
    import bsg_axil_pkg::*;
#(
    parameter int          addr_width_p = 32,
    parameter int          data_width_p = 32,
    parameter int          lat_width_p  = 16,
    parameter logic [2:0]  prot_p       = 3'b000
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,

    input  logic                      cmd_v_i,
    input  logic                      cmd_w_i,
    input  logic [addr_width_p-1:0]   cmd_addr_i,
    input  logic [data_width_p-1:0]   cmd_data_i,
    input  logic [data_width_p/8-1:0] cmd_strb_i,
    output logic                      cmd_ready_and_o,

    output logic                      resp_v_o,
    output logic                      resp_w_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [1:0]                resp_code_o,
    output logic [lat_width_p-1:0]    resp_lat_o,
    input  logic                      resp_ready_and_i,

    bsg_axil_cmd_to_master_if.master  m_axil
);
    localparam int strb_width_lp = data_width_p / 8;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [addr_width_p-1:0]   addr_q, addr_d;
    logic [data_width_p-1:0]   data_q, data_d;
    logic [strb_width_lp-1:0]  strb_q, strb_d;
    logic                      resp_w_q, resp_w_d;
    logic [data_width_p-1:0]   resp_data_q, resp_data_d;
    logic [1:0]                resp_code_q, resp_code_d;

    logic accept, busy;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign cmd_ready_and_o = (state_q == IDLE) && aresetn_i;
    assign accept          = cmd_v_i && cmd_ready_and_o;
    assign busy            = (state_q == WADDR) || (state_q == WRESP)
                          || (state_q == RADDR) || (state_q == RDATA);

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = prot_p;
    assign m_axil.awvalid = (state_q == WADDR) && !aw_done_q;
    assign m_axil.wdata   = data_q;
    assign m_axil.wstrb   = strb_q;
    assign m_axil.wvalid  = (state_q == WADDR) && !w_done_q;
    assign m_axil.bready  = (state_q == WRESP);
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = prot_p;
    assign m_axil.arvalid = (state_q == RADDR);
    assign m_axil.rready  = (state_q == RDATA);

    assign resp_v_o    = (state_q == RESP);
    assign resp_w_o    = resp_w_q;
    assign resp_data_o = resp_data_q;
    assign resp_code_o = resp_code_q;

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        resp_w_d    = resp_w_q;
        resp_data_d = resp_data_q;
        resp_code_d = resp_code_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = cmd_addr_i;
                    data_d    = cmd_data_i;
                    strb_d    = cmd_strb_i;
                    resp_w_d  = cmd_w_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_w_i ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // AW and W complete independently, possibly in the same cycle.
                aw_done_d = aw_done_q || (m_axil.awvalid && m_axil.awready);
                w_done_d  = w_done_q  || (m_axil.wvalid  && m_axil.wready);
                if (aw_done_d && w_done_d)
                    state_d = WRESP;
            end
            WRESP: begin
                if (m_axil.bvalid) begin
                    resp_code_d = m_axil.bresp;
                    resp_data_d = '0;
                    state_d     = RESP;
                end
            end
            RADDR: begin
                if (m_axil.arready)
                    state_d = RDATA;
            end
            RDATA: begin
                if (m_axil.rvalid) begin
                    resp_code_d = m_axil.rresp;
                    resp_data_d = m_axil.rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (resp_ready_and_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            resp_w_q    <= 1'b0;
            resp_data_q <= '0;
            resp_code_q <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            resp_w_q    <= resp_w_d;
            resp_data_q <= resp_data_d;
            resp_code_q <= resp_code_d;
        end
    end

    // The accept cycle counts as the first cycle, so clear and increment
    // together; the count then stops once the B/R handshake moves us to RESP.
    bsg_axil_lat_counter #(.width_p(lat_width_p)) u_lat (
        .aclk_i    (aclk_i),
        .aresetn_i (aresetn_i),
        .clear_i   (accept),
        .inc_i     (accept || busy),
        .count_o   (resp_lat_o)
    );
endmodule
